cache_fill_fsm: RTL and testbench

- Miss handler that sits directly upstream of the direct-mapped cache controller used for both the I-cache and the D-cache.
- On a miss it fetches the whole 8-word block from the multi-cycle main memory and writes each returning word into the cache data array. It then writes the tag and valid bit.
- It stalls the pipeline through `fsm_busy` for the whole fill.

---
 rtl/cache_pkg.sv | 10 +
 rtl/fill_counter.sv | 17 +
 rtl/cache_fill_fsm.sv | 68 ++++++
 tb/tb_cache_fill_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state encoding and block geometry for the cache fill path
package cache_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, TAG_WR = 2'b10} state_e;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_BYTES = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
endpackage

// File: rtl/fill_counter.sv
// fill_counter: block word counter with sticky done flag, enable and synchronous clear
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic [CNT_W:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && !cnt_q[CNT_W]) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt  = cnt_q[CNT_W-1:0];
  assign done = cnt_q[CNT_W];
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss block-fill FSM; CACHE_FILL_PERF_EN adds saturating miss/stall counters
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [CNT_W-1:0]  word_num,
`ifdef CACHE_FILL_PERF_EN
  output logic [15:0]       perf_miss_count,
  output logic [15:0]       perf_stall_cycles,
`endif
  output logic [DATA_W-1:0] fill_data
);
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-BLOCK_OFFSET_BITS){1'b1}}, {BLOCK_OFFSET_BITS{1'b0}}};
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0] req_cnt, rcv_cnt;
  logic req_done, rcv_done, in_idle, in_fill, accept, last_word;
  fill_counter u_req (.clk(clk), .rst(rst), .clr(in_idle), .en(mem_read_en), .cnt(req_cnt), .done(req_done));
  fill_counter u_rcv (.clk(clk), .rst(rst), .clr(in_idle), .en(write_data_array), .cnt(rcv_cnt), .done(rcv_done));
  always_comb begin
    in_idle          = state_q == IDLE;
    in_fill          = state_q == FILL;
    accept           = in_idle && miss_detected;
    mem_read_en      = in_fill && !req_done;
    write_data_array = in_fill && memory_data_valid && !rcv_done;
    last_word        = write_data_array && rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
    write_tag_array  = state_q == TAG_WR;
    fsm_busy         = !in_idle;
    memory_address   = mem_read_en ? base_q | ADDR_W'({req_cnt, {$clog2(WORD_BYTES){1'b0}}}) : '0;
    word_num         = write_data_array ? rcv_cnt : '0;
    fill_data        = memory_data;
    base_d           = accept ? miss_address & BASE_MASK : base_q;
    state_d          = in_idle ? (miss_detected ? FILL : IDLE) : in_fill ? (last_word ? TAG_WR : FILL) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] perf_miss_q, perf_stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && !(&perf_miss_q)) perf_miss_q <= perf_miss_q + 1'b1;
      if (fsm_busy && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end
  assign perf_miss_count   = perf_miss_q;
  assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed self-checking bench for cache_fill_fsm with a pipelined memory model
module tb_cache_fill_fsm;
  localparam int MEM_LATENCY = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data;
  logic [2:0] word_num;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] perf_miss_count, perf_stall_cycles;
`endif
  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array), .word_num(word_num),
`ifdef CACHE_FILL_PERF_EN
    .perf_miss_count(perf_miss_count), .perf_stall_cycles(perf_stall_cycles),
`endif
    .fill_data(fill_data)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] pq_addr[$];
  int pq_due[$];
  logic [15:0] addr_log[$];
  int req_cyc_log[$];
  logic [2:0] wn_log[$];
  logic [15:0] wd_log[$];
  logic busy_log[$];
  int tag_cnt, tag_cyc, last_wr_cyc;
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction
  function automatic int busy_total();
    int n = 0;
    foreach (busy_log[i]) n += int'(busy_log[i]);
    return n;
  endfunction
  task automatic clear_logs();
    addr_log.delete();
    req_cyc_log.delete();
    wn_log.delete();
    wd_log.delete();
    busy_log.delete();
    tag_cnt = 0;
    tag_cyc = -1;
    last_wr_cyc = -1;
  endtask
  task automatic step(input logic miss, input logic gap, input logic spur, input logic rst_in);
    @(negedge clk);
    rst = rst_in;
    miss_detected = miss;
    if (pq_addr.size() > 0 && pq_due[0] <= cyc && !gap) begin
      memory_data_valid = 1'b1;
      memory_data = mem_f(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end else if (spur) begin
      memory_data_valid = 1'b1;
      memory_data = 16'hDEAD;
    end else begin
      memory_data_valid = 1'b0;
      memory_data = '0;
    end
    #1;
    if (mem_read_en) begin
      addr_log.push_back(memory_address);
      req_cyc_log.push_back(cyc);
      pq_addr.push_back(memory_address);
      pq_due.push_back(cyc + MEM_LATENCY);
    end
    if (write_data_array) begin
      wn_log.push_back(word_num);
      wd_log.push_back(fill_data);
      last_wr_cyc = cyc;
    end
    if (write_tag_array) begin
      tag_cnt++;
      tag_cyc = cyc;
    end
    busy_log.push_back(fsm_busy);
    cyc++;
  endtask
  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++;
    if ({fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array, word_num} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rd=%b addr=%h wda=%b wta=%b wn=%0d, expected all 0",
               fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array, word_num);
    end
    step(0, 0, 0, 0);
    checks++;
    if (fsm_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", fsm_busy); end
  endtask
  task automatic test_basic();
    clear_logs();
    miss_address = 16'h1236;
    for (int r = 0; r < 20; r++) step(r == 0, 0, 0, 0);
    checks++;
    if (addr_log.size() != 8) begin errors++; $display("FAIL basic_req_count: got %0d expected 8", addr_log.size()); end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== 16'h1230 + 16'(2 * i)) begin
        errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, addr_log[i], 16'h1230 + 16'(2 * i));
      end
    end
    checks++;
    if (req_cyc_log.size() == 8 && req_cyc_log[7] - req_cyc_log[0] != 7) begin
      errors++; $display("FAIL basic_req_span: got %0d cycles expected 7", req_cyc_log[7] - req_cyc_log[0]);
    end
    checks++;
    if (wn_log.size() != 8) begin errors++; $display("FAIL basic_wr_count: got %0d expected 8", wn_log.size()); end
    for (int i = 0; i < 8 && i < wn_log.size(); i++) begin
      checks++;
      if (wn_log[i] !== 3'(i) || wd_log[i] !== mem_f(16'h1230 + 16'(2 * i))) begin
        errors++; $display("FAIL basic_wr[%0d]: got wn=%0d data=%h expected wn=%0d data=%h",
                           i, wn_log[i], wd_log[i], i, mem_f(16'h1230 + 16'(2 * i)));
      end
    end
    checks++;
    if (tag_cnt != 1) begin errors++; $display("FAIL basic_tag_count: got %0d expected 1", tag_cnt); end
    checks++;
    if (tag_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL basic_tag_after_last: got %0d expected %0d", tag_cyc, last_wr_cyc + 1); end
    checks++;
    if (busy_total() != 13) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 13", busy_total()); end
  endtask
  task automatic test_gaps();
    clear_logs();
    miss_address = 16'h2000;
    for (int r = 0; r < 22; r++) step(r == 0, r == 7 || r == 9, 0, 0);
    checks++;
    if (wn_log.size() != 8) begin errors++; $display("FAIL gaps_wr_count: got %0d expected 8", wn_log.size()); end
    for (int i = 0; i < 8 && i < wn_log.size(); i++) begin
      checks++;
      if (wn_log[i] !== 3'(i) || wd_log[i] !== mem_f(16'h2000 + 16'(2 * i))) begin
        errors++; $display("FAIL gaps_wr[%0d]: got wn=%0d data=%h expected wn=%0d data=%h",
                           i, wn_log[i], wd_log[i], i, mem_f(16'h2000 + 16'(2 * i)));
      end
    end
    checks++;
    if (tag_cnt != 1 || tag_cyc != last_wr_cyc + 1) begin
      errors++; $display("FAIL gaps_tag: got count=%0d cyc=%0d expected count=1 cyc=%0d", tag_cnt, tag_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (busy_total() != 15) begin errors++; $display("FAIL gaps_busy_cycles: got %0d expected 15", busy_total()); end
  endtask
  task automatic test_miss_hold();
    logic saw_spur;
    clear_logs();
    miss_address = 16'h3000;
    for (int r = 0; r < 15; r++) step(1, 0, r == 0 || r == 14, 0);
    saw_spur = 1'b0;
    foreach (wd_log[i]) if (wd_log[i] === 16'hDEAD) saw_spur = 1'b1;
    checks++;
    if (saw_spur !== 1'b0) begin errors++; $display("FAIL hold_spurious_write: got %b expected 0", saw_spur); end
    checks++;
    if (addr_log.size() != 8) begin errors++; $display("FAIL hold_single_fill_req: got %0d expected 8", addr_log.size()); end
    checks++;
    if (wn_log.size() != 8) begin errors++; $display("FAIL hold_single_fill_wr: got %0d expected 8", wn_log.size()); end
    checks++;
    if (busy_log.size() == 15 && busy_log[14] !== 1'b0) begin errors++; $display("FAIL hold_idle_gap: got %b expected 0", busy_log[14]); end
    for (int r = 0; r < 22; r++) step(0, 0, 0, 0);
    checks++;
    if (addr_log.size() != 16 || wn_log.size() != 16 || tag_cnt != 2) begin
      errors++; $display("FAIL hold_second_fill: got req=%0d wr=%0d tag=%0d expected 16 16 2", addr_log.size(), wn_log.size(), tag_cnt);
    end
    checks++;
    if (busy_total() != 26) begin errors++; $display("FAIL hold_busy_cycles: got %0d expected 26", busy_total()); end
  endtask
  task automatic test_reset_mid();
    clear_logs();
    miss_address = 16'h5550;
    for (int r = 0; r < 14; r++) begin
      step(r == 0, 0, 0, r == 8);
      if (r == 9) begin
        checks++;
        if ({fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array, word_num} !== 24'h0) begin
          errors++;
          $display("FAIL midrst_outputs: got busy=%b rd=%b addr=%h wda=%b wta=%b wn=%0d, expected all 0",
                   fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array, word_num);
        end
      end
    end
    checks++;
    if (wn_log.size() != 4) begin errors++; $display("FAIL midrst_wr_count: got %0d expected 4", wn_log.size()); end
    checks++;
    if (tag_cnt != 0) begin errors++; $display("FAIL midrst_no_tag: got %0d expected 0", tag_cnt); end
    clear_logs();
    miss_address = 16'h0400;
    for (int r = 0; r < 20; r++) step(r == 0, 0, 0, 0);
    checks++;
    if (addr_log.size() != 8 || addr_log[0] !== 16'h0400 || addr_log[7] !== 16'h040E) begin
      errors++; $display("FAIL midrst_refill_addr: got n=%0d first=%h last=%h expected n=8 first=0400 last=040e",
                         addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 16'hx, addr_log.size() > 7 ? addr_log[7] : 16'hx);
    end
    checks++;
    if (wn_log.size() != 8 || tag_cnt != 1) begin
      errors++; $display("FAIL midrst_refill_done: got wr=%0d tag=%0d expected 8 1", wn_log.size(), tag_cnt);
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] exp_a;
    step(0, 0, 0, 1);
    clear_logs();
    for (int r = 0; r < 35; r++) begin
      miss_address = r < 14 ? 16'hFFF0 : 16'h0010;
      step(r == 0 || r == 14, 0, 0, 0);
    end
    checks++;
    if (addr_log.size() != 16) begin errors++; $display("FAIL b2b_req_count: got %0d expected 16", addr_log.size()); end
    for (int i = 0; i < 16 && i < addr_log.size(); i++) begin
      exp_a = (i < 8 ? 16'hFFF0 : 16'h0010) + 16'(2 * (i % 8));
      checks++;
      if (addr_log[i] !== exp_a) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, addr_log[i], exp_a); end
      if (i < wn_log.size()) begin
        checks++;
        if (wn_log[i] !== 3'(i % 8) || wd_log[i] !== mem_f(exp_a)) begin
          errors++; $display("FAIL b2b_wr[%0d]: got wn=%0d data=%h expected wn=%0d data=%h", i, wn_log[i], wd_log[i], i % 8, mem_f(exp_a));
        end
      end
    end
    checks++;
    if (wn_log.size() != 16 || tag_cnt != 2) begin
      errors++; $display("FAIL b2b_complete: got wr=%0d tag=%0d expected 16 2", wn_log.size(), tag_cnt);
    end
    checks++;
    if (busy_total() != 26) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 26", busy_total()); end
`ifdef CACHE_FILL_PERF_EN
    checks++;
    if (perf_miss_count !== 16'd2) begin errors++; $display("FAIL perf_miss_count: got %0d expected 2", perf_miss_count); end
    checks++;
    if (perf_stall_cycles !== 16'd26) begin errors++; $display("FAIL perf_stall_cycles: got %0d expected 26", perf_stall_cycles); end
`endif
  endtask
  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_gaps();
    test_miss_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
